// File: rtl/spi_reg_master_if.sv
// -----------------------------------------------------------------------------
// spi_reg_master_if
//
// Request port of the SPI register initiator. A controller raises start for one
// cycle together with rw/addr/wdata. It then waits for the one-cycle done pulse.
// rdata, status and wr_err are valid from the done cycle onwards.
//
// Signals:
//   start   request pulse, honoured only while busy is low
//   rw      1 = write, 0 = read
//   addr    register address (ADDR_W bits)
//   wdata   write data (REG_W bits)
//   busy    transaction in progress
//   done    one-cycle completion pulse
//   rdata   last read data
//   status  byte returned by the slave during the command byte
//   wr_err  write readback mismatch flag
//
// Modports:
//   master  the requesting controller
//   slave   the spi_reg_master block
// -----------------------------------------------------------------------------
interface spi_reg_master_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0]  wdata;
  logic              busy;
  logic              done;
  logic [REG_W-1:0]  rdata;
  logic [7:0]        status;
  logic              wr_err;

  modport master (
    output start, rw, addr, wdata,
    input  busy, done, rdata, status, wr_err
  );

  modport slave (
    input  start, rw, addr, wdata,
    output busy, done, rdata, status, wr_err
  );
endinterface

// File: rtl/spi_reg_master.sv
// -----------------------------------------------------------------------------
// spi_reg_master
//
// SPI mode-0 initiator for the spireg register slave. Each request produces one
// frame on the pins. A frame is a command byte {rw, 0.., addr} followed by a
// REG_W-bit data byte, both sent MSB first. On write frames mosi carries wdata
// during the data byte. On read frames mosi is 0 during the data byte and miso
// is captured into rdata. The byte that the slave returns during the command
// byte is reported on status.
//
// Optional feature (macro SPIM_VERIFY_EN):
//   Every write frame is followed by an automatic read frame of the same
//   address. A single done pulse is issued after that read frame. wr_err then
//   flags a readback mismatch. Without the macro, wr_err is tied to 0.
//
// Ports:
//   clk   system clock; all logic runs on its rising edge
//   rst   synchronous, active-high reset
//   req   request port (spi_reg_master_if.slave): start/rw/addr/wdata in;
//         busy/done/rdata/status/wr_err out
//   nss   active-low chip select
//   sclk  SPI clock, idle low
//   mosi  master data out
//   miso  slave data in
//
// Parameters:
//   ADDR_W   register address width (1..7)
//   REG_W    register data width
//   CLK_DIV  clk cycles per sclk half-period (>=1)
//   CS_GAP   clk cycles with nss high after each frame (>=1)
// -----------------------------------------------------------------------------
module spi_reg_master #(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_reg_master_if.slave   req,
  output logic              nss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int FRAME_W = 8 + REG_W;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   div_cnt_reg;   // cycles spent in the current half-period or gap
  logic [BIT_W-1:0]   bit_cnt_reg;   // index of the bit currently on the wire
  logic               high_reg;      // 1 while in the sclk-high half of a bit
  logic [FRAME_W-1:0] tx_sr_reg;     // outgoing frame; MSB is the bit on mosi
  logic [FRAME_W-1:0] rx_sr_reg;     // incoming frame; status byte ends up on top
  logic               rw_reg;

  logic               nss_reg;
  logic               sclk_reg;
  logic               mosi_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [REG_W-1:0]   rdata_reg;
  logic [7:0]         status_reg;

`ifdef SPIM_VERIFY_EN
  logic               verify_reg;    // the frame in flight is the automatic readback
  logic [7:0]         rb_cmd_reg;    // read command of the address just written
  logic [REG_W-1:0]   wdata_reg;     // reference value for the readback compare
  logic               wr_err_reg;
`endif

  // Command byte: bit 7 carries rw, the low ADDR_W bits carry the address,
  // and any bits in between are zero.
  logic [7:0] cmd_req;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cmd
      if (gi == 7) begin : g_rw
        assign cmd_req[gi] = req.rw;
      end else if (gi < ADDR_W) begin : g_addr
        assign cmd_req[gi] = req.addr[gi];
      end else begin : g_pad
        assign cmd_req[gi] = 1'b0;
      end
    end
  endgenerate

  // On a read, the data byte on mosi is all zeros.
  logic [REG_W-1:0] wdata_frame;
  assign wdata_frame = req.rw ? req.wdata : '0;

  logic [7:0]       frame_status;
  logic [REG_W-1:0] frame_data;
  assign frame_status = rx_sr_reg[FRAME_W-1 -: 8];
  assign frame_data   = rx_sr_reg[REG_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      high_reg    <= 1'b0;
      tx_sr_reg   <= '0;
      rx_sr_reg   <= '0;
      rw_reg      <= 1'b0;
      nss_reg     <= 1'b1;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rdata_reg   <= '0;
      status_reg  <= '0;
`ifdef SPIM_VERIFY_EN
      verify_reg  <= 1'b0;
      rb_cmd_reg  <= '0;
      wdata_reg   <= '0;
      wr_err_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // busy is always low in IDLE. This includes the done cycle, so a new
          // start can be accepted there.
          if (req.start) begin
            rw_reg      <= req.rw;
            tx_sr_reg   <= {cmd_req, wdata_frame};
            mosi_reg    <= cmd_req[7];
            nss_reg     <= 1'b0;
            sclk_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            high_reg    <= 1'b0;
`ifdef SPIM_VERIFY_EN
            verify_reg  <= 1'b0;
            rb_cmd_reg  <= {1'b0, cmd_req[6:0]};
            wdata_reg   <= req.wdata;
`endif
            state_reg   <= SETUP;
          end
        end

        SETUP: begin
          if (div_cnt_reg == DIV_LAST) begin
            // miso is captured on the same edge that raises sclk. The slave
            // drives each bit during the preceding low phase.
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b1;
            high_reg    <= 1'b1;
            rx_sr_reg   <= {rx_sr_reg[FRAME_W-2:0], miso};
            state_reg   <= SHIFT;
          end else begin
            div_cnt_reg <= div_cnt_reg + CNT_W'(1);
          end
        end

        SHIFT: begin
          if (div_cnt_reg != DIV_LAST) begin
            div_cnt_reg <= div_cnt_reg + CNT_W'(1);
          end else begin
            div_cnt_reg <= '0;
            if (high_reg) begin
              // Falling edge: present the next bit.
              sclk_reg  <= 1'b0;
              high_reg  <= 1'b0;
              tx_sr_reg <= {tx_sr_reg[FRAME_W-2:0], 1'b0};
              mosi_reg  <= tx_sr_reg[FRAME_W-2];
            end else if (bit_cnt_reg == BIT_LAST) begin
              nss_reg   <= 1'b1;
              mosi_reg  <= 1'b0;
              state_reg <= GAP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
              sclk_reg    <= 1'b1;
              high_reg    <= 1'b1;
              rx_sr_reg   <= {rx_sr_reg[FRAME_W-2:0], miso};
            end
          end
        end

        GAP: begin
          if (div_cnt_reg != GAP_LAST) begin
            div_cnt_reg <= div_cnt_reg + CNT_W'(1);
          end else begin
            div_cnt_reg <= '0;
`ifdef SPIM_VERIFY_EN
            if (rw_reg && !verify_reg) begin
              // The write is complete. Read the same register back before
              // reporting done.
              verify_reg  <= 1'b1;
              tx_sr_reg   <= {rb_cmd_reg, {REG_W{1'b0}}};
              mosi_reg    <= rb_cmd_reg[7];
              nss_reg     <= 1'b0;
              bit_cnt_reg <= '0;
              high_reg    <= 1'b0;
              state_reg   <= SETUP;
            end else begin
              state_reg  <= IDLE;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
              status_reg <= frame_status;
              verify_reg <= 1'b0;
              if (verify_reg) begin
                rdata_reg  <= frame_data;
                wr_err_reg <= (frame_data != wdata_reg);
              end else begin
                // Only read frames reach this branch, and they clear the flag.
                rdata_reg  <= frame_data;
                wr_err_reg <= 1'b0;
              end
            end
`else
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            status_reg <= frame_status;
            if (!rw_reg) begin
              rdata_reg <= frame_data;
            end
`endif
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign nss         = nss_reg;
  assign sclk        = sclk_reg;
  assign mosi        = mosi_reg;
  assign req.busy    = busy_reg;
  assign req.done    = done_reg;
  assign req.rdata   = rdata_reg;
  assign req.status  = status_reg;
`ifdef SPIM_VERIFY_EN
  assign req.wr_err  = wr_err_reg;
`else
  assign req.wr_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_master
//
// Drives spi_reg_master against a behavioural spireg slave. The slave is an
// 8-entry register memory. It returns mem[0] as the status byte and it commits
// a write only when it has seen a complete 16-bit frame. Expected completion
// values are queued when a request is issued. They are popped and compared when
// done is seen.
// -----------------------------------------------------------------------------
module tb_spi_reg_master;
  localparam int ADDR_W  = 3;
  localparam int REG_W   = 8;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;
  localparam int FRAME_CYC = CLK_DIV * (1 + 2 * (8 + REG_W)) + CS_GAP;
  localparam int RD_LAT    = 1 + FRAME_CYC;                      // 135
`ifdef SPIM_VERIFY_EN
  localparam bit VERIFY    = 1'b1;
  localparam int WR_LAT    = 2 * FRAME_CYC + 1;                  // 269
`else
  localparam bit VERIFY    = 1'b0;
  localparam int WR_LAT    = RD_LAT;
`endif

  logic clk = 1'b0;
  logic rst;
  logic nss, sclk, mosi, miso;

  spi_reg_master_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  spi_reg_master #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W),
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (bus),
    .nss (nss),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso)
  );

  always #5 clk = ~clk;

  int cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // ---------------- spireg slave model (edges detected on negedge clk) -------
  logic [7:0]  mem [0:7];
  logic [7:0]  out_sr, out_next;
  logic [15:0] in_sr;
  logic        nss_q, sclk_q;
  logic        init_done = 1'b0;
  logic        stuck0;
  int          s_cnt;
  int          n_frames = 0;
  logic [15:0] frame_log [0:63];
  int          rise_log  [0:63];
  wire  [7:0]  cmd_now = {in_sr[6:0], mosi};

  always @(negedge clk) begin
    nss_q  <= nss;
    sclk_q <= sclk;
    if (!init_done) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'(8'h11 * i);
      mem[0]    <= 8'h01;
      miso      <= 1'b0;
      s_cnt     <= 0;
      in_sr     <= '0;
      out_sr    <= '0;
      out_next  <= '0;
      init_done <= 1'b1;
    end else if (nss_q === 1'b1 && nss === 1'b0) begin
      s_cnt  <= 0;
      out_sr <= mem[0];
      miso   <= mem[0][7];
    end else if (nss === 1'b0 && sclk === 1'b1 && sclk_q === 1'b0) begin
      in_sr <= {in_sr[14:0], mosi};
      s_cnt <= s_cnt + 1;
      if (s_cnt == 7) out_next <= cmd_now[7] ? 8'h00 : mem[cmd_now[2:0]];
    end else if (nss === 1'b0 && sclk === 1'b0 && sclk_q === 1'b1) begin
      if (s_cnt == 8) begin
        out_sr <= out_next;
        miso   <= out_next[7];
      end else begin
        out_sr <= {out_sr[6:0], 1'b0};
        miso   <= out_sr[6];
      end
    end else if (nss_q === 1'b0 && nss === 1'b1) begin
      frame_log[n_frames] <= in_sr;
      rise_log[n_frames]  <= s_cnt;
      n_frames            <= n_frames + 1;
      if (s_cnt == 16 && in_sr[15])
        mem[in_sr[10:8]] <= stuck0 ? (in_sr[7:0] & 8'hFE) : in_sr[7:0];
    end
  end

  // ---------------- scoreboard and bookkeeping ------------------------------
  typedef struct {
    logic [7:0] rdata;
    logic [7:0] status;
    logic       wr_err;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cyc;

  // The call is made at a negedge. It pulses start for one cycle and returns at
  // the negedge of cycle 1. The request inputs are then scrambled, so the bench
  // also shows that the DUT latched them.
  task automatic issue(input logic rw_i, input logic [2:0] addr_i, input logic [7:0] wdata_i);
    bus.rw    = rw_i;
    bus.addr  = addr_i;
    bus.wdata = wdata_i;
    bus.start = 1'b1;
    start_cyc = cyc_now;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rw    = ~rw_i;
    bus.addr  = 3'($urandom);
    bus.wdata = 8'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit timeout);
    timeout = 1'b1;
    lat     = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.done === 1'b1) begin
        timeout = 1'b0;
        lat     = cyc_now - start_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (nss !== 1'b1) begin errors++; $display("FAIL reset_nss: got %b expected 1", nss); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", bus.busy, bus.done); end
    checks++; if (bus.rdata !== 8'h00 || bus.status !== 8'h00) begin errors++; $display("FAIL reset_regs: got rdata %h status %h expected 00 00", bus.rdata, bus.status); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", bus.wr_err); end
    $display("txn reset: nss=%b sclk=%b busy=%b rdata=%h status=%h", nss, sclk, bus.busy, bus.rdata, bus.status);
  endtask

  task automatic test_write();
    int lat; bit to; int f0; exp_t e;
    f0 = n_frames;
    exp_q.push_back('{rdata: (VERIFY ? 8'hA5 : 8'h00), status: 8'h01, wr_err: 1'b0, lat: WR_LAT});
    issue(1'b1, 3'd2, 8'hA5);
    checks++; if (bus.busy !== 1'b1 || nss !== 1'b0) begin errors++; $display("FAIL write_cycle1: got busy %b nss %b expected 1 0", bus.busy, nss); end
    wait_done(lat, to);
    e = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL write_timeout: got no done expected done"); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL write_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL write_busy_at_done: got %b expected 0", bus.busy); end
    checks++; if (bus.rdata !== e.rdata || bus.status !== e.status || bus.wr_err !== e.wr_err) begin errors++; $display("FAIL write_outputs: got %h/%h/%b expected %h/%h/%b", bus.rdata, bus.status, bus.wr_err, e.rdata, e.status, e.wr_err); end
    checks++; if (frame_log[f0] !== 16'h82A5) begin errors++; $display("FAIL write_mosi: got %h expected 82a5", frame_log[f0]); end
    checks++; if (rise_log[f0] !== 16) begin errors++; $display("FAIL write_sclk_rises: got %0d expected 16", rise_log[f0]); end
    checks++; if (mem[2] !== 8'hA5) begin errors++; $display("FAIL write_mem2: got %h expected a5", mem[2]); end
    checks++; if (n_frames !== f0 + (VERIFY ? 2 : 1)) begin errors++; $display("FAIL write_frames: got %0d expected %0d", n_frames - f0, VERIFY ? 2 : 1); end
    if (VERIFY) begin
      checks++; if (frame_log[f0+1] !== 16'h0200) begin errors++; $display("FAIL write_readback_mosi: got %h expected 0200", frame_log[f0+1]); end
    end
    $display("txn write addr=2 data=a5: lat=%0d frame=%h status=%h", lat, frame_log[f0], bus.status);
  endtask

  task automatic test_read();
    int lat; bit to; int f0; exp_t e;
    f0 = n_frames;
    exp_q.push_back('{rdata: 8'hA5, status: 8'h01, wr_err: 1'b0, lat: RD_LAT});
    issue(1'b0, 3'd2, 8'hFF);
    wait_done(lat, to);
    e = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL read_timeout: got no done expected done"); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (bus.rdata !== e.rdata || bus.status !== e.status || bus.wr_err !== e.wr_err) begin errors++; $display("FAIL read_outputs: got %h/%h/%b expected %h/%h/%b", bus.rdata, bus.status, bus.wr_err, e.rdata, e.status, e.wr_err); end
    checks++; if (frame_log[f0] !== 16'h0200) begin errors++; $display("FAIL read_mosi: got %h expected 0200", frame_log[f0]); end
    $display("txn read addr=2: lat=%0d rdata=%h status=%h", lat, bus.rdata, bus.status);
  endtask

  task automatic test_busy_reject();
    int lat; bit to; int f0; int extra; exp_t e;
    f0 = n_frames;
    exp_q.push_back('{rdata: (VERIFY ? 8'h5A : 8'hA5), status: 8'h01, wr_err: 1'b0, lat: WR_LAT});
    issue(1'b1, 3'd1, 8'h5A);
    while (cyc_now - start_cyc < 50) @(negedge clk);
    bus.rw = 1'b1; bus.addr = 3'd5; bus.wdata = 8'hEE; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, to);
    e = exp_q.pop_front();
    extra = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    checks++; if (to) begin errors++; $display("FAIL busy_timeout: got no done expected done"); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (bus.rdata !== e.rdata || bus.status !== e.status) begin errors++; $display("FAIL busy_outputs: got %h/%h expected %h/%h", bus.rdata, bus.status, e.rdata, e.status); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_extra_done: got %0d expected 0", extra); end
    checks++; if (n_frames !== f0 + (VERIFY ? 2 : 1)) begin errors++; $display("FAIL busy_frames: got %0d expected %0d", n_frames - f0, VERIFY ? 2 : 1); end
    checks++; if (mem[5] !== 8'h55 || mem[1] !== 8'h5A) begin errors++; $display("FAIL busy_mem: got mem5 %h mem1 %h expected 55 5a", mem[5], mem[1]); end
    $display("txn write addr=1 data=5a with rejected start: lat=%0d frames=%0d", lat, n_frames - f0);
  endtask

  task automatic test_reset_mid_frame();
    int lat; bit to; int f0; int extra; exp_t e;
    f0 = n_frames;
    issue(1'b1, 3'd3, 8'h3C);
    while (cyc_now - start_cyc < 60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (nss !== 1'b1 || sclk !== 1'b0) begin errors++; $display("FAIL abort_pins: got nss %b sclk %b expected 1 0", nss, sclk); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_busy_done: got %b%b expected 00", bus.busy, bus.done); end
    checks++; if (bus.rdata !== 8'h00 || bus.status !== 8'h00) begin errors++; $display("FAIL abort_regs: got %h/%h expected 00/00", bus.rdata, bus.status); end
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", extra); end
    checks++; if (mem[3] !== 8'h33) begin errors++; $display("FAIL abort_mem3: got %h expected 33", mem[3]); end
    checks++; if (rise_log[f0] >= 16) begin errors++; $display("FAIL abort_rises: got %0d expected below 16", rise_log[f0]); end
    $display("txn aborted write addr=3: sclk rises before reset=%0d", rise_log[f0]);

    exp_q.push_back('{rdata: 8'h44, status: 8'h01, wr_err: 1'b0, lat: RD_LAT});
    issue(1'b0, 3'd4, 8'h00);
    wait_done(lat, to);
    e = exp_q.pop_front();
    checks++; if (to || lat !== e.lat) begin errors++; $display("FAIL post_abort_latency: got %0d expected %0d", lat, e.lat); end
    checks++; if (bus.rdata !== e.rdata || bus.status !== e.status) begin errors++; $display("FAIL post_abort_read: got %h/%h expected %h/%h", bus.rdata, bus.status, e.rdata, e.status); end
    $display("txn read addr=4: lat=%0d rdata=%h", lat, bus.rdata);
  endtask

`ifdef SPIM_VERIFY_EN
  task automatic test_verify();
    int lat; bit to; int f0; exp_t e;
    // Table: {stuck model, write data, expected readback, expected wr_err}.
    // 0x3C has bit0 = 0, so a stuck-0 bit0 would go unnoticed. The stuck case
    // therefore writes 0x3D.
    logic [7:0] wd [0:1];
    logic [7:0] rb [0:1];
    logic       er [0:1];
    wd[0] = 8'h3C; rb[0] = 8'h3C; er[0] = 1'b0;
    wd[1] = 8'h3D; rb[1] = 8'h3C; er[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      stuck0 = (k == 1);
      f0 = n_frames;
      exp_q.push_back('{rdata: rb[k], status: 8'h01, wr_err: er[k], lat: WR_LAT});
      issue(1'b1, 3'd7, wd[k]);
      wait_done(lat, to);
      e = exp_q.pop_front();
      checks++; if (to || lat !== e.lat) begin errors++; $display("FAIL verify_latency[%0d]: got %0d expected %0d", k, lat, e.lat); end
      checks++; if (bus.rdata !== e.rdata || bus.wr_err !== e.wr_err) begin errors++; $display("FAIL verify_result[%0d]: got %h/%b expected %h/%b", k, bus.rdata, bus.wr_err, e.rdata, e.wr_err); end
      checks++; if (frame_log[f0] !== {8'h87, wd[k]} || frame_log[f0+1] !== 16'h0700) begin errors++; $display("FAIL verify_frames[%0d]: got %h %h expected %h 0700", k, frame_log[f0], frame_log[f0+1], {8'h87, wd[k]}); end
      $display("txn verified write addr=7 data=%h: lat=%0d rdata=%h wr_err=%b", wd[k], lat, bus.rdata, bus.wr_err);
    end
    stuck0 = 1'b0;
    exp_q.push_back('{rdata: 8'h3C, status: 8'h01, wr_err: 1'b0, lat: RD_LAT});
    issue(1'b0, 3'd7, 8'h00);
    wait_done(lat, to);
    e = exp_q.pop_front();
    checks++; if (to || bus.wr_err !== e.wr_err || bus.rdata !== e.rdata) begin errors++; $display("FAIL verify_read_clears: got %h/%b expected %h/%b", bus.rdata, bus.wr_err, e.rdata, e.wr_err); end
    $display("txn read addr=7: rdata=%h wr_err=%b", bus.rdata, bus.wr_err);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    stuck0    = 1'b0;
    bus.start = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_busy_reject();
    test_reset_mid_frame();
`ifdef SPIM_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
